// File: rtl/vx_barrier_sched_pkg.sv
// Shared types for the warp barrier scheduler: slot-state encoding and a width helper.
package vx_barrier_sched_pkg;

   typedef enum logic [1:0] {
      BAR_IDLE    = 2'd0,
      BAR_COLLECT = 2'd1,
      BAR_GWAIT   = 2'd2
   } bar_state_t;

   function automatic int bits_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_barrier_sched_if.sv
// Arrival / release / global-barrier bundle between GPU unit, scheduler and warp scheduler.
// Global-barrier signals exist only when VX_BARRIER_GLOBAL_EN is defined.
interface vx_barrier_sched_if
   import vx_barrier_sched_pkg::*;
#(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_BARRIERS = 4
);
   localparam int NW_BITS = bits_min1(NUM_WARPS);
   localparam int NB_BITS = bits_min1(NUM_BARRIERS);

   logic                 req_valid;
   logic                 req_ready;
   logic [NW_BITS-1:0]   req_wid;
   logic [NB_BITS-1:0]   req_id;
   logic [NW_BITS-1:0]   req_size_m1;
   logic                 req_is_global;
   logic                 rel_valid;
   logic                 rel_ready;
   logic [NB_BITS-1:0]   rel_id;
   logic [NUM_WARPS-1:0] rel_wmask;
   logic [NUM_WARPS-1:0] stalled_wmask;
   logic                 err;
`ifdef VX_BARRIER_GLOBAL_EN
   logic                 gbar_req_valid;
   logic [NB_BITS-1:0]   gbar_req_id;
   logic [NW_BITS-1:0]   gbar_req_size_m1;
   logic                 gbar_req_ready;
   logic                 gbar_rsp_valid;
   logic [NB_BITS-1:0]   gbar_rsp_id;

   modport master (
      output req_valid, req_wid, req_id, req_size_m1, req_is_global, rel_ready,
             gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
      input  req_ready, rel_valid, rel_id, rel_wmask, stalled_wmask, err,
             gbar_req_valid, gbar_req_id, gbar_req_size_m1
   );
   modport slave (
      input  req_valid, req_wid, req_id, req_size_m1, req_is_global, rel_ready,
             gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
      output req_ready, rel_valid, rel_id, rel_wmask, stalled_wmask, err,
             gbar_req_valid, gbar_req_id, gbar_req_size_m1
   );
`else
   modport master (
      output req_valid, req_wid, req_id, req_size_m1, req_is_global, rel_ready,
      input  req_ready, rel_valid, rel_id, rel_wmask, stalled_wmask, err
   );
   modport slave (
      input  req_valid, req_wid, req_id, req_size_m1, req_is_global, rel_ready,
      output req_ready, rel_valid, rel_id, rel_wmask, stalled_wmask, err
   );
`endif
endinterface

// File: rtl/vx_barrier_sched_slot.sv
// One barrier slot: arrival mask, arrival counter and IDLE/COLLECT/GWAIT state machine.
// GWAIT handling is compiled in only with VX_BARRIER_GLOBAL_EN.
module vx_barrier_sched_slot
   import vx_barrier_sched_pkg::*;
#(
   parameter int NUM_WARPS = 4,
   parameter int NW_BITS   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 arr_valid_i,
   input  logic [NW_BITS-1:0]   arr_wid_i,
   input  logic [NW_BITS-1:0]   arr_size_m1_i,
`ifdef VX_BARRIER_GLOBAL_EN
   input  logic                 arr_is_global_i,
   input  logic                 rsp_hit_i,
   input  logic                 send_ack_i,
   output logic                 gwait_o,
   output logic                 sent_o,
   output logic [NW_BITS-1:0]   size_m1_o,
`endif
   output logic [NUM_WARPS-1:0] wmask_o,
   output logic                 done_o,
   output logic [NUM_WARPS-1:0] done_wmask_o,
   output logic                 err_o
);
   typedef struct packed {
      bar_state_t           state;
      logic [NUM_WARPS-1:0] wmask;
      logic [NW_BITS-1:0]   count;
      logic [NW_BITS-1:0]   size_m1;
      logic                 is_global;
      logic                 sent;
   } bar_slot_t;

   bar_slot_t            slot_q, slot_d;
   logic [NUM_WARPS-1:0] wbit_s, wmask_new_s;
   logic [NW_BITS-1:0]   cnt_new_s, size_eff_s;
   logic                 glob_in_s, glob_eff_s, dup_s, complete_s;

`ifdef VX_BARRIER_GLOBAL_EN
   assign glob_in_s = arr_is_global_i;
`else
   assign glob_in_s = 1'b0;
`endif

   // Next-state for arrival, global response and request-sent bookkeeping
   always_comb begin
      slot_d       = slot_q;
      err_o        = 1'b0;
      done_o       = 1'b0;
      done_wmask_o = '0;
      dup_s        = 1'b0;
      wbit_s       = NUM_WARPS'(1) << arr_wid_i;
      if (slot_q.state == BAR_IDLE) begin
         wmask_new_s = wbit_s;
         cnt_new_s   = '0;
         size_eff_s  = arr_size_m1_i;
         glob_eff_s  = glob_in_s;
      end else begin
         wmask_new_s = slot_q.wmask | wbit_s;
         cnt_new_s   = slot_q.count + NW_BITS'(1);
         size_eff_s  = slot_q.size_m1;
         glob_eff_s  = slot_q.is_global;
         dup_s       = |(slot_q.wmask & wbit_s);
      end
      complete_s = (cnt_new_s == size_eff_s);

      if (arr_valid_i) begin
         if ((slot_q.state == BAR_GWAIT) || dup_s) begin
            err_o = 1'b1;
         end else if (complete_s && !glob_eff_s) begin
            done_o       = 1'b1;
            done_wmask_o = wmask_new_s;
            slot_d       = '0;
         end else begin
            slot_d.state     = complete_s ? BAR_GWAIT : BAR_COLLECT;
            slot_d.wmask     = wmask_new_s;
            slot_d.count     = cnt_new_s;
            slot_d.size_m1   = size_eff_s;
            slot_d.is_global = glob_eff_s;
            slot_d.sent      = 1'b0;
         end
      end
`ifdef VX_BARRIER_GLOBAL_EN
      else if (rsp_hit_i && (slot_q.state == BAR_GWAIT)) begin
         done_o       = 1'b1;
         done_wmask_o = slot_q.wmask;
         slot_d       = '0;
      end else if (send_ack_i) begin
         slot_d.sent = 1'b1;
      end
`endif
      else begin
         slot_d = slot_q;
      end
   end

   // Slot state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) slot_q <= '0;
      else       slot_q <= slot_d;
   end

   assign wmask_o = slot_q.wmask;
`ifdef VX_BARRIER_GLOBAL_EN
   assign gwait_o   = (slot_q.state == BAR_GWAIT);
   assign sent_o    = slot_q.sent;
   assign size_m1_o = slot_q.size_m1;
`endif
endmodule

// File: rtl/vx_barrier_sched.sv
// Warp barrier scheduler top: slot array, single-entry release register, sticky error.
// Define VX_BARRIER_GLOBAL_EN to add the global-barrier request/response path.
module vx_barrier_sched
   import vx_barrier_sched_pkg::*;
#(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_BARRIERS = 4
) (
   input  logic              clk,
   input  logic              reset,
   vx_barrier_sched_if.slave bus
);
   localparam int NW_BITS = bits_min1(NUM_WARPS);
   localparam int NB_BITS = bits_min1(NUM_BARRIERS);

   logic [NUM_BARRIERS-1:0] arr_hit_s, done_s, err_s;
   logic [NUM_WARPS-1:0]    wmask_s      [NUM_BARRIERS];
   logic [NUM_WARPS-1:0]    done_wmask_s [NUM_BARRIERS];
   logic                    fire_s, rsp_blk_s, rel_hit_s, err_hit_s;
   logic [NB_BITS-1:0]      rel_id_s;
   logic [NUM_WARPS-1:0]    rel_mask_s, stall_s;

   logic                    rel_valid_q, rel_valid_d, err_q, err_d;
   logic [NB_BITS-1:0]      rel_id_q, rel_id_d;
   logic [NUM_WARPS-1:0]    rel_wmask_q, rel_wmask_d;

`ifdef VX_BARRIER_GLOBAL_EN
   logic [NUM_BARRIERS-1:0] gwait_s, sent_s, rsp_hit_s, send_ack_s;
   logic [NW_BITS-1:0]      size_s [NUM_BARRIERS];
   logic                    gv_s;
   logic [NB_BITS-1:0]      gid_s;
   logic [NW_BITS-1:0]      gsize_s;

   // A global response owns the release register in its cycle
   assign rsp_blk_s = bus.gbar_rsp_valid;
`else
   logic unused_glob_s;
   assign unused_glob_s = bus.req_is_global;
   assign rsp_blk_s     = 1'b0;
`endif

   assign bus.req_ready = (~rel_valid_q | bus.rel_ready) & ~rsp_blk_s;
   assign fire_s        = bus.req_valid & bus.req_ready;

   for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_slot
      assign arr_hit_s[gi] = fire_s && (bus.req_id == NB_BITS'(gi));
`ifdef VX_BARRIER_GLOBAL_EN
      assign rsp_hit_s[gi]  = bus.gbar_rsp_valid && (bus.gbar_rsp_id == NB_BITS'(gi));
      assign send_ack_s[gi] = gv_s && bus.gbar_req_ready && (gid_s == NB_BITS'(gi));
`endif
      vx_barrier_sched_slot #(.NUM_WARPS(NUM_WARPS), .NW_BITS(NW_BITS)) u_slot (
         .clk           (clk),
         .reset         (reset),
         .arr_valid_i   (arr_hit_s[gi]),
         .arr_wid_i     (bus.req_wid),
         .arr_size_m1_i (bus.req_size_m1),
`ifdef VX_BARRIER_GLOBAL_EN
         .arr_is_global_i (bus.req_is_global),
         .rsp_hit_i     (rsp_hit_s[gi]),
         .send_ack_i    (send_ack_s[gi]),
         .gwait_o       (gwait_s[gi]),
         .sent_o        (sent_s[gi]),
         .size_m1_o     (size_s[gi]),
`endif
         .wmask_o       (wmask_s[gi]),
         .done_o        (done_s[gi]),
         .done_wmask_o  (done_wmask_s[gi]),
         .err_o         (err_s[gi])
      );
   end

   // At most one slot completes per cycle, so an OR-merge selects it
   always_comb begin
      rel_hit_s  = 1'b0;
      rel_id_s   = '0;
      rel_mask_s = '0;
      stall_s    = '0;
      err_hit_s  = 1'b0;
      for (int i = 0; i < NUM_BARRIERS; i++) begin
         stall_s   = stall_s | wmask_s[i];
         err_hit_s = err_hit_s | err_s[i];
         if (done_s[i]) begin
            rel_hit_s  = 1'b1;
            rel_id_s   = NB_BITS'(i);
            rel_mask_s = rel_mask_s | done_wmask_s[i];
         end else begin
            rel_mask_s = rel_mask_s;
         end
      end
   end

`ifdef VX_BARRIER_GLOBAL_EN
   // Lowest-index GWAIT slot whose request has not yet been accepted
   always_comb begin
      gv_s    = 1'b0;
      gid_s   = '0;
      gsize_s = '0;
      for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
         if (gwait_s[i] && !sent_s[i]) begin
            gv_s    = 1'b1;
            gid_s   = NB_BITS'(i);
            gsize_s = size_s[i];
         end else begin
            gv_s = gv_s;
         end
      end
   end

   assign bus.gbar_req_valid   = gv_s;
   assign bus.gbar_req_id      = gid_s;
   assign bus.gbar_req_size_m1 = gsize_s;
`endif

   // Release register: reload wins over drain, giving back-to-back releases
   always_comb begin
      rel_valid_d = rel_valid_q;
      rel_id_d    = rel_id_q;
      rel_wmask_d = rel_wmask_q;
      err_d       = err_q | err_hit_s;
      if (rel_hit_s) begin
         rel_valid_d = 1'b1;
         rel_id_d    = rel_id_s;
         rel_wmask_d = rel_mask_s;
      end else if (rel_valid_q && bus.rel_ready) begin
         rel_valid_d = 1'b0;
      end else begin
         rel_valid_d = rel_valid_q;
      end
   end

   // Release and error registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rel_valid_q <= 1'b0;
         rel_id_q    <= '0;
         rel_wmask_q <= '0;
         err_q       <= 1'b0;
      end else begin
         rel_valid_q <= rel_valid_d;
         rel_id_q    <= rel_id_d;
         rel_wmask_q <= rel_wmask_d;
         err_q       <= err_d;
      end
   end

   assign bus.rel_valid     = rel_valid_q;
   assign bus.rel_id        = rel_id_q;
   assign bus.rel_wmask     = rel_wmask_q;
   assign bus.stalled_wmask = stall_s;
   assign bus.err           = err_q;
endmodule

// File: doc/vx_barrier_sched.md
# VX_barrier_sched

Warp barrier scheduler for the GPU unit's warp-control path. It consumes barrier arrivals decoded from `INST_GPU_BAR`, tracks per-barrier arrival masks and counts, and emits a single release when the expected number of warps has arrived. The warp scheduler uses the release to un-stall those warps. It sits between the GPU unit's warp-control response and the warp scheduler, and owns all barrier state for one core.

## Interface
- `NUM_WARPS`, default 4: warps per core.
- `NUM_BARRIERS`, default 4: barrier slots; `NB_BITS = $clog2(NUM_BARRIERS)` (min 1).
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous and active-high; all state clears immediately on assertion.
- `req_valid` in 1: barrier arrival.
- `req_ready` out 1: arrival accepted when `req_valid && req_ready`.
- `req_wid` in `NW_BITS`: arriving warp.
- `req_id` in `NB_BITS`: barrier slot.
- `req_size_m1` in `NW_BITS`: expected warp count minus 1.
- `req_is_global` in 1: global-barrier flag (see Configuration).
- `rel_valid` out 1: release available.
- `rel_ready` in 1: consumer accepts the release.
- `rel_id` out `NB_BITS`: released barrier.
- `rel_wmask` out `NUM_WARPS`: warps to un-stall.
- `stalled_wmask` out `NUM_WARPS`: OR of all collecting masks.
- `err` out 1: sticky protocol error.

## Operation
- Each slot holds `state`, `wmask`, `count` (`NW_BITS`), `size_m1` and `is_global`. State is one of IDLE, COLLECT or GWAIT.
- **Arrival at an IDLE slot:**
  - latches `size_m1` and `is_global`;
  - sets `wmask = 1<<wid` and `count = 0`;
  - state becomes COLLECT.
- **Arrival at a COLLECT slot:** ORs in the wid bit and sets `count = count+1`. The latched `size_m1` applies; a later differing `req_size_m1` is ignored.
- **Completion:** occurs when the post-update count equals `size_m1`. For `size_m1==0` this happens on the first arrival.
  - On a local completion, load the release register with `{id, wmask_new}` and return the slot to IDLE.
- **Errors:** `err` sets and stays set, and the arrival is dropped with slot state unchanged, in these cases:
  - duplicate warp: the wid bit is already set in `wmask`;
  - arrival at a GWAIT slot.
- **Release register:**
  - one entry;
  - `rel_valid` holds until `rel_valid && rel_ready`;
  - `req_ready = ~rel_valid | rel_ready`, AND-ed with the global-response term below.
- `stalled_wmask` is the OR of `wmask` over all COLLECT and GWAIT slots. A warp that completes a barrier never appears in it.
- Different barriers are independent; any number may collect at once.

## Timing
- **Reset values:**
  - `req_ready=1`;
  - `rel_valid=0`, `rel_id=0`, `rel_wmask=0`;
  - `stalled_wmask=0`;
  - `err=0`;
  - all slots IDLE.
- An arrival that fires in cycle N updates `stalled_wmask` at N+1.
- A completing arrival in cycle N gives `rel_valid=1` at N+1; latency is one cycle.
- Simultaneous release drain (`rel_ready=1`) and a new completing arrival in the same cycle: the register reloads with no bubble.
- Reset asserted mid-collect drops every pending barrier. Upstream warps must be reset with this block.

## Configuration
- Macro: `VX_BARRIER_GLOBAL_EN`.
- **Defined:** adds these ports:
  - `gbar_req_valid` out 1;
  - `gbar_req_id` out `NB_BITS`;
  - `gbar_req_size_m1` out `NW_BITS`;
  - `gbar_req_ready` in 1;
  - `gbar_rsp_valid` in 1;
  - `gbar_rsp_id` in `NB_BITS`.
- **Behaviour with the macro defined:**
  - Completion of a slot with latched `is_global=1` moves it to GWAIT instead of releasing.
  - `gbar_req_valid` is asserted for the lowest-index GWAIT slot not yet sent (tracked by a per-slot `sent` bit) and holds until `gbar_req_ready`.
  - `gbar_rsp_valid` with id k (a GWAIT slot) loads the release register with slot k's mask and returns k to IDLE. The response has no ready and must be accepted in its cycle.
  - While `gbar_rsp_valid=1`, `req_ready=0`, so the response always wins the release register. Upstream guarantees the register is drainable: `rel_ready` is held high.
- **Undefined:** `req_is_global` is ignored (a local barrier); there is no GWAIT state and no gbar ports.

## Structure
- Shared package `VX_gpu_types`:
  - the slot-state enum `bar_state_t` {IDLE, COLLECT, GWAIT};
  - the struct `bar_slot_t` {state, wmask, count, size_m1, is_global, sent}.
- Natural sub-module: `VX_barrier_slot`, one instance per barrier, holding the state machine and counter, with a generate loop in the top.
- The top handles the release register, global-request priority select and `err`.

## Test plan
- **Basic release:** NUM_WARPS=4; bar 1 with size_m1=2; arrivals from w0, w2, w3 in consecutive cycles. Expect `stalled_wmask` 0001 then 0101, then 0000 when w3 arrives. `rel_valid` asserts one cycle after w3 with `rel_id=1`, `rel_wmask=1101`.
- **Single-warp barrier:** size_m1=0, w1 arrives at bar 0. Expect `rel_valid` next cycle with `rel_wmask=0010`, and `stalled_wmask` never shows w1.
- **Backpressure:** hold `rel_ready=0` after a release. Expect `req_ready=0` and the register held stable. Raise `rel_ready` with a completing arrival in the same cycle: expect back-to-back releases.
- **Duplicate error:** w2 arrives twice at bar 3 with size_m1=3. Expect `err=1`, count still 0 and mask 0100.
- **Global barrier (macro defined):** is_global=1, size_m1=1, w0 and w1 arrive. Expect `gbar_req_valid` with id and size_m1=1 and no release. A later `gbar_rsp_valid` id=k gives `rel_wmask=0011` next cycle.
- **Async reset:** assert reset mid-COLLECT with two barriers active. Expect all outputs at reset values immediately, before the next clock edge.
